// File: rtl/led_matrix_scanner_if.sv
// Tile-write bus between game/control logic and the LED matrix scanner.
// Latency: wr_ack returns one cycle after a write is accepted.
// Backpressure: none; a write is either accepted on its edge or dropped.
//
// Signals:
//   freeze  - 1 = writes are ignored (scan keeps running)
//   wr_en   - tile write request, sampled every rising edge
//   wr_mode - 0 OR, 1 overwrite, 2 XOR, 3 clear tile
//   area    - tile index
//   dot     - tile pixels, MSB = top-left, raster order
//   wr_ack  - one-cycle pulse, the write on the previous edge was accepted
interface led_matrix_scanner_if #(
  parameter int AW = 3,
  parameter int DW = 16
);
  logic          freeze;
  logic          wr_en;
  logic [1:0]    wr_mode;
  logic [AW-1:0] area;
  logic [DW-1:0] dot;
  logic          wr_ack;

  // Control logic side: issues writes, observes the acknowledge.
  modport master (
    output freeze,
    output wr_en,
    output wr_mode,
    output area,
    output dot,
    input  wr_ack
  );

  // Scanner side: consumes writes, returns the acknowledge.
  modport slave (
    input  freeze,
    input  wr_en,
    input  wr_mode,
    input  area,
    input  dot,
    output wr_ack
  );
endinterface

// File: rtl/led_matrix_scanner.sv
// Tile-addressed frame buffer multiplexed one row at a time onto LED matrix drivers.
// Latency: writes land on the accepting edge, wr_ack one cycle later; row/col reload every SCAN_DIV clocks.
// Backpressure: none; writes are always accepted unless frozen or out of range, scan never stalls.
//
// Ports:
//   clock      - system clock, rising edge
//   reset      - asynchronous active-low reset
//   wr         - tile write bus (freeze, wr_en, wr_mode, area, dot, wr_ack)
//   blink_en   - enable the blink overlay
//   row        - row select, one row active at a time
//   col        - column data of the displayed row, 1 = lit
//   frame_done - one-cycle pulse on the load that shows the last row
module led_matrix_scanner #(
  parameter int ROWS           = 8,
  parameter int COLS           = 16,
  parameter int TILE           = 4,
  parameter int SCAN_DIV       = 5000,
  parameter int BLINK_FRAMES   = 32,
  parameter int ROW_ACTIVE_LOW = 1
) (
  input  logic                clock,
  input  logic                reset,
  led_matrix_scanner_if.slave wr,
  input  logic                blink_en,
  output logic [ROWS-1:0]     row,
  output logic [COLS-1:0]     col,
  output logic                frame_done
);

  localparam int NTX  = COLS / TILE;
  localparam int NTY  = ROWS / TILE;
  localparam int NT   = NTX * NTY;
  localparam int AW   = (NT > 1) ? $clog2(NT) : 1;
  localparam int DW   = TILE * TILE;
  localparam int RIW  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int DIVW = $clog2(SCAN_DIV);
  localparam int FCW  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  // Level of every row driver when nothing is selected; a selected row is
  // this pattern with its own bit flipped, which covers both polarities.
  localparam logic [ROWS-1:0] ROW_IDLE = (ROW_ACTIVE_LOW != 0) ? '1 : '0;

  // Frame buffer: one packed word per matrix row, bit COLS-1 is the left column.
  logic [COLS-1:0] buf_q [ROWS];
  logic [COLS-1:0] buf_d [ROWS];

  logic [DIVW-1:0] div_q;
  logic [RIW-1:0]  idx_q;
  logic [FCW-1:0]  fcnt_q;
  logic            phase_q;

  logic [ROWS-1:0] row_q;
  logic [COLS-1:0] col_q;
  logic            frame_done_q;
  logic            wr_ack_q;

  logic accept;
  logic in_range;
  logic div_last;
  logic idx_last;
  logic fcnt_last;
  logic blank;

  // Columns covered by tile column tx. Tile column 0 sits at the left edge,
  // i.e. the top bits of a buffer word.
  function automatic logic [COLS-1:0] col_mask(input int tx);
    col_mask = COLS'({TILE{1'b1}}) << (COLS - TILE - tx * TILE);
  endfunction

  // Pixel row r of the tile payload, placed at tile column tx. The payload
  // is raster ordered from the MSB, so tile row 0 is the top TILE bits.
  function automatic logic [COLS-1:0] dot_row(input logic [DW-1:0] d,
                                              input int r, input int tx);
    dot_row = COLS'(TILE'(d >> (DW - TILE - r * TILE))) << (COLS - TILE - tx * TILE);
  endfunction

  // Per-pixel update of one buffer word. Overwrite and clear only touch the
  // masked columns; OR and XOR are naturally confined because bits is zero
  // outside the tile.
  function automatic logic [COLS-1:0] merge(input logic [COLS-1:0] old,
                                            input logic [COLS-1:0] mask,
                                            input logic [COLS-1:0] bits,
                                            input logic [1:0]      mode);
    case (mode)
      2'd0:    merge = old | bits;
      2'd1:    merge = (old & ~mask) | bits;
      2'd2:    merge = old ^ bits;
      default: merge = old & ~mask;
    endcase
  endfunction

  // With a non power-of-two tile count the upper area codes do not map to
  // any tile and must be rejected rather than aliased.
  assign in_range = ({1'b0, wr.area} < (AW + 1)'(NT));
  assign accept   = wr.wr_en & ~wr.freeze & in_range;

  assign div_last  = (div_q == DIVW'(SCAN_DIV - 1));
  assign idx_last  = (idx_q == RIW'(ROWS - 1));
  assign fcnt_last = (fcnt_q == FCW'(BLINK_FRAMES - 1));
  assign blank     = blink_en & phase_q;

  // Next buffer contents. The tile loop is static so every tile's row and
  // column placement is a constant; only the matching tile is rewritten.
  always_comb begin
    for (int y = 0; y < ROWS; y++) begin
      buf_d[y] = buf_q[y];
    end
    for (int t = 0; t < NT; t++) begin
      if (accept && (wr.area == AW'(t))) begin
        for (int r = 0; r < TILE; r++) begin
          buf_d[RIW'((t / NTX) * TILE + r)] =
            merge(buf_q[RIW'((t / NTX) * TILE + r)],
                  col_mask(t % NTX),
                  dot_row(wr.dot, r, t % NTX),
                  wr.wr_mode);
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int y = 0; y < ROWS; y++) begin
        buf_q[y] <= '0;
      end
      div_q        <= '0;
      idx_q        <= '0;
      fcnt_q       <= '0;
      phase_q      <= 1'b0;
      row_q        <= ROW_IDLE;
      col_q        <= '0;
      frame_done_q <= 1'b0;
      wr_ack_q     <= 1'b0;
    end else begin
      for (int y = 0; y < ROWS; y++) begin
        buf_q[y] <= buf_d[y];
      end
      wr_ack_q     <= accept;
      frame_done_q <= 1'b0;

      if (div_last) begin
        div_q <= '0;
        // Reads buf_q, not buf_d: a write on this same edge shows up on the
        // next visit to the row, never half-way through a displayed row.
        row_q <= (ROWS'(1) << idx_q) ^ ROW_IDLE;
        col_q <= blank ? '0 : buf_q[idx_q];
        if (idx_last) begin
          idx_q        <= '0;
          frame_done_q <= 1'b1;
          // The phase runs whether or not blinking is enabled, so turning
          // blink on later stays locked to the frame cadence.
          if (fcnt_last) begin
            fcnt_q  <= '0;
            phase_q <= ~phase_q;
          end else begin
            fcnt_q <= fcnt_q + 1'b1;
          end
        end else begin
          idx_q <= idx_q + 1'b1;
        end
      end else begin
        div_q <= div_q + 1'b1;
      end
    end
  end

  assign row        = row_q;
  assign col        = col_q;
  assign frame_done = frame_done_q;
  assign wr.wr_ack  = wr_ack_q;

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Self-checking bench for led_matrix_scanner (8x16, 4x4 tiles, SCAN_DIV=4, BLINK_FRAMES=2),
// plus a 8x12 instance whose tile count leaves unused area codes.
// A pixel-level reference model tracks buffer, scan position and blink phase from edge counts.
module tb_led_matrix_scanner;

  localparam int SD = 4;
  localparam int BF = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic blink_en;

  logic [7:0]  dut_row;
  logic [15:0] dut_col;
  logic        dut_fd;

  logic [7:0]  row2;
  logic [11:0] col2;
  logic        fd2;

  int checks = 0;
  int errors = 0;

  led_matrix_scanner_if #(.AW(3), .DW(16)) wif ();
  led_matrix_scanner_if #(.AW(3), .DW(16)) wif2 ();

  led_matrix_scanner #(
    .ROWS(8), .COLS(16), .TILE(4), .SCAN_DIV(SD), .BLINK_FRAMES(BF), .ROW_ACTIVE_LOW(1)
  ) dut (
    .clock(clk), .reset(rst_n), .wr(wif), .blink_en(blink_en),
    .row(dut_row), .col(dut_col), .frame_done(dut_fd)
  );

  led_matrix_scanner #(
    .ROWS(8), .COLS(12), .TILE(4), .SCAN_DIV(SD), .BLINK_FRAMES(32), .ROW_ACTIVE_LOW(1)
  ) dut2 (
    .clock(clk), .reset(rst_n), .wr(wif2), .blink_en(1'b0),
    .row(row2), .col(col2), .frame_done(fd2)
  );

  always #5 clk = ~clk;

  // ---------------- reference model of the 8x16 instance ----------------
  logic [15:0] m_buf [8];
  logic [7:0]  m_row;
  logic [15:0] m_col;
  logic        m_fd;
  logic        m_ack;
  int          m_k;
  int          m_load, m_r, m_f, m_py, m_pc;
  logic        m_d, m_old;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int y = 0; y < 8; y++) m_buf[y] = 16'h0;
      m_row = 8'hFF; m_col = 16'h0; m_fd = 1'b0; m_ack = 1'b0; m_k = 0;
    end else begin
      m_k  = m_k + 1;
      m_fd = 1'b0;
      // Scan: the n-th load happens on edge n*SD and shows row (n-1) mod 8.
      if (m_k % SD == 0) begin
        m_load = m_k / SD;
        m_r    = (m_load - 1) % 8;
        m_f    = (m_load - 1) / 8;
        m_row  = ~(8'(1) << m_r);
        m_col  = (blink_en && ((m_f / BF) % 2 == 1)) ? 16'h0 : m_buf[3'(m_r)];
        m_fd   = (m_r == 7);
      end
      // Write: pixel by pixel over the tile in raster order.
      m_ack = 1'b0;
      if (wif.wr_en && !wif.freeze && int'(wif.area) < 8) begin
        m_ack = 1'b1;
        for (int i = 0; i < 16; i++) begin
          m_py  = (int'(wif.area) / 4) * 4 + i / 4;
          m_pc  = 15 - (int'(wif.area) % 4) * 4 - i % 4;
          m_d   = wif.dot[4'(15 - i)];
          m_old = m_buf[3'(m_py)][4'(m_pc)];
          case (wif.wr_mode)
            2'd0: m_buf[3'(m_py)][4'(m_pc)] = m_old | m_d;
            2'd1: m_buf[3'(m_py)][4'(m_pc)] = m_d;
            2'd2: m_buf[3'(m_py)][4'(m_pc)] = m_old ^ m_d;
            default: m_buf[3'(m_py)][4'(m_pc)] = 1'b0;
          endcase
        end
      end
    end
  end

  // ---------------- helpers (stimulus / waiting only) ----------------
  task automatic do_write(input logic [1:0] mode, input logic [2:0] a, input logic [15:0] d,
                          output logic ack1, output logic ack2);
    wif.wr_en = 1'b1; wif.wr_mode = mode; wif.area = a; wif.dot = d;
    @(negedge clk); ack1 = wif.wr_ack; wif.wr_en = 1'b0;
    @(negedge clk); ack2 = wif.wr_ack;
  endtask

  task automatic do_write2(input logic [1:0] mode, input logic [2:0] a, input logic [15:0] d,
                           output logic ack1, output logic ack2);
    wif2.wr_en = 1'b1; wif2.wr_mode = mode; wif2.area = a; wif2.dot = d;
    @(negedge clk); ack1 = wif2.wr_ack; wif2.wr_en = 1'b0;
    @(negedge clk); ack2 = wif2.wr_ack;
  endtask

  // Waits (bounded) until the model shows row r selected; a timeout is a failure.
  task automatic wait_row(input int r);
    logic [7:0] want;
    bit hit;
    want = ~(8'(1) << r);
    hit  = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      if (m_row === want) hit = 1'b1;
      else @(negedge clk);
    end
    if (!hit) begin
      checks++; errors++;
      $display("FAIL wait_row%0d: row=%b never reached, required %b", r, dut_row, want);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (dut_row !== 8'hFF) begin errors++; $display("FAIL reset_row: got %h required ff", dut_row); end
    checks++; if (dut_col !== 16'h0) begin errors++; $display("FAIL reset_col: got %h required 0000", dut_col); end
    checks++; if (dut_fd !== 1'b0 || wif.wr_ack !== 1'b0) begin errors++; $display("FAIL reset_pulses: fd=%b ack=%b required 0 0", dut_fd, wif.wr_ack); end
    rst_n = 1'b1;
    for (int e = 1; e <= 40; e++) begin
      @(negedge clk);
      checks++;
      if (dut_row !== m_row || dut_col !== m_col || dut_fd !== m_fd || wif.wr_ack !== m_ack) begin
        errors++;
        $display("FAIL scan_edge%0d: row=%h col=%h fd=%b ack=%b required %h %h %b %b",
                 e, dut_row, dut_col, dut_fd, wif.wr_ack, m_row, m_col, m_fd, m_ack);
      end
      if (e == 3) begin
        checks++; if (dut_row !== 8'hFF) begin errors++; $display("FAIL before_first_load: row=%h required ff", dut_row); end
      end
      if (e == 4) begin
        checks++; if (dut_row !== 8'hFE || dut_col !== 16'h0) begin errors++; $display("FAIL first_load: row=%h col=%h required fe 0000", dut_row, dut_col); end
      end
      if (e == 32) begin
        checks++; if (dut_row !== 8'h7F || dut_fd !== 1'b1) begin errors++; $display("FAIL row7_load: row=%h fd=%b required 7f 1", dut_row, dut_fd); end
      end
      if (e == 33) begin
        checks++; if (dut_fd !== 1'b0) begin errors++; $display("FAIL fd_width: fd=%b required 0", dut_fd); end
      end
      if (e == 36) begin
        checks++; if (dut_row !== 8'hFE) begin errors++; $display("FAIL row0_reload: row=%h required fe", dut_row); end
      end
    end
  endtask

  task automatic test_out_of_range();
    logic a1, a2;
    bit saw7;
    do_write2(2'd1, 3'd6, 16'hFFFF, a1, a2);
    checks++; if (a1 !== 1'b0 || a2 !== 1'b0) begin errors++; $display("FAIL oor_area6_ack: %b%b required 00", a1, a2); end
    do_write2(2'd0, 3'd7, 16'hFFFF, a1, a2);
    checks++; if (a1 !== 1'b0 || a2 !== 1'b0) begin errors++; $display("FAIL oor_area7_ack: %b%b required 00", a1, a2); end
    repeat (36) @(negedge clk);
    saw7 = 1'b0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      saw7 |= (row2 == 8'h7F);
      checks++; if (col2 !== 12'h0) begin errors++; $display("FAIL oor_buffer: row=%h col=%h required 000", row2, col2); end
    end
    checks++; if (!saw7) begin errors++; $display("FAIL oor_scan: last row seen=%b required 1", saw7); end
    do_write2(2'd1, 3'd5, 16'hFFFF, a1, a2);
    checks++; if (a1 !== 1'b1 || a2 !== 1'b0) begin errors++; $display("FAIL area5_ack: %b%b required 10", a1, a2); end
    repeat (36) @(negedge clk);
    for (int i = 0; i < 32; i++) begin
      logic [7:0]  sel;
      logic [11:0] want;
      @(negedge clk);
      sel  = ~row2;
      want = (sel[7:4] != 4'h0) ? 12'h00F : 12'h000;
      checks++; if (col2 !== want) begin errors++; $display("FAIL area5_col: row=%h col=%h required %h", row2, col2, want); end
    end
  endtask

  task automatic test_write_modes();
    logic a1, a2;
    do_write(2'd0, 3'd0, 16'h8001, a1, a2);
    checks++; if (a1 !== 1'b1 || a2 !== 1'b0) begin errors++; $display("FAIL or_ack: %b%b required 10", a1, a2); end
    repeat (36) @(negedge clk);
    wait_row(0);
    checks++; if (dut_col !== 16'h8000) begin errors++; $display("FAIL or_row0: col=%h required 8000", dut_col); end
    wait_row(3);
    checks++; if (dut_col !== 16'h1000) begin errors++; $display("FAIL or_row3: col=%h required 1000", dut_col); end

    do_write(2'd1, 3'd7, 16'hFFFF, a1, a2);
    checks++; if (a1 !== 1'b1 || a2 !== 1'b0) begin errors++; $display("FAIL ovw_ack: %b%b required 10", a1, a2); end
    repeat (36) @(negedge clk);
    for (int r = 4; r < 8; r++) begin
      wait_row(r);
      checks++; if (dut_col !== 16'h000F) begin errors++; $display("FAIL ovw_row%0d: col=%h required 000f", r, dut_col); end
    end

    do_write(2'd2, 3'd0, 16'h8001, a1, a2);
    repeat (36) @(negedge clk);
    wait_row(0);
    checks++; if (dut_col !== 16'h0) begin errors++; $display("FAIL xor1_row0: col=%h required 0000", dut_col); end
    do_write(2'd2, 3'd0, 16'h8001, a1, a2);
    repeat (36) @(negedge clk);
    wait_row(0);
    checks++; if (dut_col !== 16'h8000) begin errors++; $display("FAIL xor2_row0: col=%h required 8000", dut_col); end

    do_write(2'd3, 3'd7, 16'($urandom), a1, a2);
    checks++; if (a1 !== 1'b1) begin errors++; $display("FAIL clr_ack: %b required 1", a1); end
    repeat (36) @(negedge clk);
    for (int r = 4; r < 8; r++) begin
      wait_row(r);
      checks++; if (dut_col !== 16'h0) begin errors++; $display("FAIL clr_row%0d: col=%h required 0000", r, dut_col); end
    end
  endtask

  task automatic test_freeze();
    int acks, pulses;
    acks = 0; pulses = 0;
    wif.freeze = 1'b1; wif.wr_en = 1'b1; wif.wr_mode = 2'd1; wif.area = 3'd0; wif.dot = 16'hFFFF;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (wif.wr_ack !== 1'b0) acks++;
      if (dut_fd === 1'b1) pulses++;
    end
    wif.wr_en = 1'b0; wif.freeze = 1'b0;
    checks++; if (acks != 0) begin errors++; $display("FAIL freeze_ack: %0d acks required 0", acks); end
    checks++; if (pulses != 1) begin errors++; $display("FAIL freeze_scan: %0d frame pulses required 1", pulses); end
    repeat (36) @(negedge clk);
    wait_row(0);
    checks++; if (dut_col !== 16'h8000) begin errors++; $display("FAIL freeze_row0: col=%h required 8000", dut_col); end
    wait_row(1);
    checks++; if (dut_col !== 16'h0) begin errors++; $display("FAIL freeze_row1: col=%h required 0000", dut_col); end
  endtask

  task automatic test_blink();
    logic a1, a2;
    int load, r, f;
    logic [15:0] want;
    do_reset();
    blink_en = 1'b1;
    do_write(2'd1, 3'd0, 16'hFFFF, a1, a2);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      checks++;
      if (dut_row !== m_row || dut_col !== m_col || dut_fd !== m_fd) begin
        errors++;
        $display("FAIL blink_model k=%0d: row=%h col=%h fd=%b required %h %h %b", m_k, dut_row, dut_col, dut_fd, m_row, m_col, m_fd);
      end
      if (m_k % SD == 0 && m_k >= SD) begin
        load = m_k / SD; r = (load - 1) % 8; f = (load - 1) / 8;
        if (f < 6) begin
          want = (r < 4 && f != 2 && f != 3) ? 16'hF000 : 16'h0;
          checks++;
          if (dut_col !== want || dut_row !== ~(8'(1) << r)) begin
            errors++;
            $display("FAIL blink_frame%0d_row%0d: row=%h col=%h required %h %h", f, r, dut_row, dut_col, ~(8'(1) << r), want);
          end
        end
      end
    end
    // Reset in the middle of a frame with a write pending.
    wif.wr_en = 1'b1; wif.wr_mode = 2'd1; wif.area = 3'd2; wif.dot = 16'hFFFF;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checks++; if (dut_row !== 8'hFF || dut_col !== 16'h0) begin errors++; $display("FAIL async_reset: row=%h col=%h required ff 0000", dut_row, dut_col); end
    checks++; if (dut_fd !== 1'b0 || wif.wr_ack !== 1'b0) begin errors++; $display("FAIL async_reset_pulses: fd=%b ack=%b required 0 0", dut_fd, wif.wr_ack); end
    wif.wr_en = 1'b0; blink_en = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (36) @(negedge clk);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      checks++; if (dut_col !== 16'h0 || dut_row !== m_row) begin errors++; $display("FAIL post_reset_empty: row=%h col=%h required %h 0000", dut_row, dut_col, m_row); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      checks++;
      if (dut_row !== m_row || dut_col !== m_col || dut_fd !== m_fd || wif.wr_ack !== m_ack) begin
        errors++;
        $display("FAIL random_cycle%0d: row=%h col=%h fd=%b ack=%b required %h %h %b %b",
                 i, dut_row, dut_col, dut_fd, wif.wr_ack, m_row, m_col, m_fd, m_ack);
      end
      wif.wr_en   = ($urandom_range(0, 1) == 1);
      wif.freeze  = ($urandom_range(0, 4) == 0);
      wif.wr_mode = 2'($urandom_range(0, 3));
      wif.area    = 3'($urandom_range(0, 7));
      wif.dot     = 16'($urandom);
      if ($urandom_range(0, 19) == 0) blink_en = ~blink_en;
    end
    wif.wr_en = 1'b0; wif.freeze = 1'b0;
  endtask

  initial begin
    wif.freeze = 1'b0; wif.wr_en = 1'b0; wif.wr_mode = 2'd0; wif.area = 3'd0; wif.dot = 16'h0;
    wif2.freeze = 1'b0; wif2.wr_en = 1'b0; wif2.wr_mode = 2'd0; wif2.area = 3'd0; wif2.dot = 16'h0;
    blink_en = 1'b0;
    test_reset();
    test_out_of_range();
    test_write_modes();
    test_freeze();
    test_blink();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
